switch_key_input_pio: RTL and testbench
=======================================

// Module: switch_key_input_pio
// PURPOSE
//  Avalon-MM slave input port: reader-side counterpart of the LED output PIO.
//  Samples asynchronous board inputs (slide switches/keys), synchronises and debounces
//  them, records any-edge events and raises a maskable level interrupt to the HPS.
//  Instantiated inside the Qsys system on the lightweight HPS-to-FPGA bridge.
// PARAMETERS
//  WIDTH            10     number of input pins, legal range 1..32
//  DEBOUNCE_CYCLES  50000  consecutive cycles a new level must persist (1 ms @ 50 MHz), >=1
//  CNT_W            16     debounce counter width; must hold DEBOUNCE_CYCLES-1
// PORTS
//  clk_clk        in   1      system clock
//  reset_reset_n  in   1      asynchronous active-low reset
//  avs_address    in   2      word address
//  avs_read       in   1      read strobe, fixed read latency 1
//  avs_write      in   1      write strobe, zero wait states
//  avs_writedata  in   32     write data
//  avs_readdata   out  32     read data, valid the cycle after avs_read
//  irq            out  1      level interrupt, active high
//  pio_in         in   WIDTH  asynchronous external inputs
// BEHAVIOUR
//  Reset: all internal registers 0, so avs_readdata=0, irq=0.
//  - Sync: 2-FF synchroniser per bit (s2), reset 0.
//  - Debounce, per bit: counter cleared whenever s2==stable. Counter increments while s2!=stable.
//    - stable<=s2 on the cycle the counter equals DEBOUNCE_CYCLES-1, and the counter clears.
//    - Counter never wraps. A one-cycle return to the old level restarts the count.
//  - Register map (32-bit words, unused upper bits read 0):
//    - 0 DATA: RO, stable[WIDTH-1:0]. Writes are ignored.
//    - 1: reserved. Reads 0; writes are ignored.
//    - 2 IRQ_MASK: RW, reset 0.
//    - 3 EDGE_CAPTURE: RO, W1C. Writing 1 to a bit clears it.
//  - Edge capture: stable_d is stable delayed by 1. A bit is set when stable!=stable_d, i.e.
//    one cycle after stable changes. Rising and falling edges are both captured.
//  - Set has priority over a W1C clear of the same bit in the same cycle.
//  - irq = |(edge_capture & irq_mask). It is combinational from registers only, so glitch-free.
//  - Reads: avs_readdata is registered on avs_read and holds its value otherwise.
//    - A read and a write in the same cycle perform the write.
//    - The read returns the pre-write value.
//  - Inputs high at reset release go to stable=1 after debounce and set EDGE_CAPTURE.
//    Software clears this after init.
//  - Reset mid-debounce: counters and stable clear immediately; no edge is recorded for the reset.
//  - Pin-to-DATA latency: 2 (sync) + DEBOUNCE_CYCLES cycles.
//    EDGE_CAPTURE sets 1 cycle after DATA changes.
// CONFIGURATION
//  INPUT_PIO_DEBOUNCE_EN defined: debounce counters present as described.
//  Not defined: no counters; stable<=s2 every cycle, giving a pin-to-DATA latency of 3 cycles.
//    Pulses of one cycle or longer are captured as two edges. DEBOUNCE_CYCLES and CNT_W are unused.
// TESTING (bench with DEBOUNCE_CYCLES=4, WIDTH=10)
//  1. Reset with pio_in=0, then read addr 0,2,3 -> all 0x0000_0000. irq=0 throughout.
//  2. pio_in[0] 0->1 held -> DATA reads 0x001 from 6 cycles after the change.
//     EDGE_CAPTURE=0x001 one cycle later. irq stays 0 (mask 0).
//  3. pio_in[3] high for 3 cycles, then low -> DATA stays 0x000 and EDGE_CAPTURE stays 0x000.
//  4. Write 0x001 to addr 2, then edge on bit0 -> irq=1.
//     Write 0x001 to addr 3 -> EDGE_CAPTURE=0 and irq=0 on the next cycle.
//  5. W1C of bit0 in the same cycle that bit0's edge is captured -> EDGE_CAPTURE[0]=1 and irq stays 1.
//  6. Build without INPUT_PIO_DEBOUNCE_EN: 1-cycle pulse on pio_in[5] -> DATA bit5 high for one cycle.
//     EDGE_CAPTURE=0x020.

Source files
------------

// File: rtl/switch_key_input_pio.sv
// Avalon-MM input PIO: synchronises, optionally debounces (INPUT_PIO_DEBOUNCE_EN) and
// edge-captures board inputs, with a maskable level interrupt.
module switch_key_input_pio #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] pio_in
);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] stable_dly_q, stable_dly_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] w1c;
  logic [31:0]      rd_mux;

`ifdef INPUT_PIO_DEBOUNCE_EN
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic             unused_ok;
  assign unused_ok = ^avs_writedata;
`else
  logic             unused_ok;
  assign unused_ok = ^{avs_writedata, DEBOUNCE_CYCLES[0], CNT_W[0]};
`endif

  always_comb begin
    s1_d = pio_in;
    s2_d = s1_q;
`ifdef INPUT_PIO_DEBOUNCE_EN
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      // Any cycle back at the stable level restarts the count from zero.
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
`else
    stable_d = s2_q;
`endif
    stable_dly_d = stable_q;

    w1c = '0;
    if (avs_write && avs_address == 2'd3) w1c = avs_writedata[WIDTH-1:0];
    // New edges win over a simultaneous software clear.
    edge_cap_d = (edge_cap_q & ~w1c) | (stable_q ^ stable_dly_q);

    irq_mask_d = irq_mask_q;
    if (avs_write && avs_address == 2'd2) irq_mask_d = avs_writedata[WIDTH-1:0];

    rd_mux = '0;
    case (avs_address)
      2'd0:    rd_mux[WIDTH-1:0] = stable_q;
      2'd2:    rd_mux[WIDTH-1:0] = irq_mask_q;
      2'd3:    rd_mux[WIDTH-1:0] = edge_cap_q;
      default: rd_mux = '0;
    endcase
    readdata_d = avs_read ? rd_mux : readdata_q;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      s1_q         <= '0;
      s2_q         <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      edge_cap_q   <= '0;
      irq_mask_q   <= '0;
      readdata_q   <= '0;
`ifdef INPUT_PIO_DEBOUNCE_EN
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
`endif
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      edge_cap_q   <= edge_cap_d;
      irq_mask_q   <= irq_mask_d;
      readdata_q   <= readdata_d;
`ifdef INPUT_PIO_DEBOUNCE_EN
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
`endif
    end
  end

  assign avs_readdata = readdata_q;
  assign irq          = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_switch_key_input_pio.sv
// Directed bench for switch_key_input_pio (WIDTH=10, DEBOUNCE_CYCLES=4); covers both
// the debounced and the plain build.
module tb_switch_key_input_pio;

  localparam int WIDTH = 10;
`ifdef INPUT_PIO_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       avs_address = '0;
  logic             avs_read = 1'b0;
  logic             avs_write = 1'b0;
  logic [31:0]      avs_writedata = '0;
  logic [31:0]      avs_readdata;
  logic             irq;
  logic [WIDTH-1:0] pio_in = '0;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rd;

  switch_key_input_pio #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .irq(irq), .pio_in(pio_in)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
    avs_address = a;
    avs_read    = 1'b1;
    tick(1);
    avs_read = 1'b0;
    v = avs_readdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    tick(1);
    avs_write = 1'b0;
  endtask

  initial begin
    // Reset with inputs low
    tick(3);
    check("rst_readdata", avs_readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    rst_n = 1'b1;
    tick(1);

    // Test 1: idle register reads
    bus_read(2'd0, rd); check("t1_data", rd, 32'h0);
    bus_read(2'd2, rd); check("t1_mask", rd, 32'h0);
    bus_read(2'd3, rd); check("t1_edge", rd, 32'h0);
    check("t1_irq", {31'b0, irq}, 32'h0);

    // Test 2: bit0 rises; DATA latency boundary, then edge capture
    avs_address = 2'd0;
    avs_read    = 1'b1;
    pio_in[0]   = 1'b1;
    tick(LAT);
    check("t2_data_before", avs_readdata, 32'h0);
    tick(1);
    check("t2_data_after", avs_readdata, 32'h1);
    avs_address = 2'd3;
    tick(1);
    check("t2_edge", avs_readdata, 32'h1);
    check("t2_irq_masked", {31'b0, irq}, 32'h0);
    avs_read = 1'b0;
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, rd); check("t2_edge_cleared", rd, 32'h0);

`ifdef INPUT_PIO_DEBOUNCE_EN
    // Test 3: 3-cycle glitch on bit3 is filtered
    pio_in[3] = 1'b1;
    tick(3);
    pio_in[3] = 1'b0;
    tick(8);
    bus_read(2'd0, rd); check("t3_data", rd, 32'h1);
    bus_read(2'd3, rd); check("t3_edge", rd, 32'h0);
`else
    // Test 6: 1-cycle pulse on bit5 passes through as two edges
    avs_address = 2'd0;
    avs_read    = 1'b1;
    pio_in[5]   = 1'b1;
    tick(1);
    pio_in[5] = 1'b0;
    tick(2);
    check("t6_data_pre", avs_readdata, 32'h001);
    tick(1);
    check("t6_data_pulse", avs_readdata, 32'h021);
    tick(1);
    check("t6_data_post", avs_readdata, 32'h001);
    avs_read = 1'b0;
    tick(2);
    bus_read(2'd3, rd); check("t6_edge", rd, 32'h020);
    bus_write(2'd3, 32'h020);
    bus_read(2'd3, rd); check("t6_edge_cleared", rd, 32'h0);
`endif

    // Test 4: masked interrupt, W1C clears it
    bus_write(2'd2, 32'h1);
    bus_read(2'd2, rd); check("t4_mask", rd, 32'h1);
    check("t4_irq_idle", {31'b0, irq}, 32'h0);
    pio_in[0] = 1'b0;
    tick(LAT + 2);
    check("t4_irq_set", {31'b0, irq}, 32'h1);
    bus_read(2'd3, rd); check("t4_edge", rd, 32'h1);
    bus_write(2'd3, 32'h1);
    check("t4_irq_clr", {31'b0, irq}, 32'h0);
    bus_read(2'd3, rd); check("t4_edge_clr", rd, 32'h0);

    // Test 5: W1C coinciding with capture loses to the set
    pio_in[0] = 1'b1;
    tick(LAT);
    check("t5_irq_pre", {31'b0, irq}, 32'h0);
    avs_address   = 2'd3;
    avs_writedata = 32'h1;
    avs_write     = 1'b1;
    tick(1);
    avs_write = 1'b0;
    check("t5_irq_kept", {31'b0, irq}, 32'h1);
    bus_read(2'd3, rd); check("t5_edge_kept", rd, 32'h1);

    // Read and write in the same cycle: old value returned, write applied
    avs_address   = 2'd2;
    avs_writedata = 32'h0;
    avs_read      = 1'b1;
    avs_write     = 1'b1;
    tick(1);
    avs_read  = 1'b0;
    avs_write = 1'b0;
    check("rw_old_value", avs_readdata, 32'h1);
    check("rw_irq_unmasked", {31'b0, irq}, 32'h0);
    bus_read(2'd2, rd); check("rw_new_mask", rd, 32'h0);

    // DATA and reserved word ignore writes
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_read(2'd0, rd); check("data_ro", rd, 32'h1);
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1, rd); check("reserved", rd, 32'h0);
    tick(1);
    check("readdata_hold", avs_readdata, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
